mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The module SHALL have these ports, one per line: name  direction  width  meaning.
- clk_50MHz  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hold current WB contents.
- flush  in  1  replace next WB contents with bubble.
- in_valid  in  1  MEM stage presents an instruction.
- in_reg_op  in  3  destination class: 0 NOP, 1 REG, 2 T, 3 SP, 4 IH, 5 RA; 6 and 7 are treated as NOP.
- in_wb_addr  in  3  general register index.
- in_alu_data  in  16  ALU/immediate result.
- in_is_load  in  1  result comes from memory.
- mem_rdata  in  16  memory read data.
- mem_ready  in  1  memory read data valid this cycle.
- reg_op  out  3  register-file write class.
- wb_addr  out  3  register-file write index.
- wb_data  out  16  register-file write data.
- busy  out  1  load pending; upstream must stall.
- fwd_A_hit, fwd_B_hit  out  1 each  (WB_FWD_EN only) bypass match.
- fwd_data  out  16  (WB_FWD_EN only) bypass value, equal to wb_data.
- A_addr, B_addr  in  3 each  (WB_FWD_EN only) decode-stage read indices.

Function
REQ-002 The state machine SHALL have two states: IDLE and WAIT_MEM.
REQ-003 In IDLE with in_valid=1, in_is_load=0 and stall=0, the module SHALL latch in_reg_op, in_wb_addr and in_alu_data into reg_op, wb_addr and wb_data on the next posedge.
- Latency: 1 cycle.
REQ-004 In IDLE with in_valid=1, in_is_load=1 and mem_ready=1, the module SHALL latch mem_rdata as wb_data in the same edge.
- No state change.
REQ-005 In IDLE with in_valid=1, in_is_load=1 and mem_ready=0, the module SHALL:
- latch in_reg_op and in_wb_addr into a pending register;
- set reg_op=NOP;
- enter WAIT_MEM.
REQ-006 busy SHALL be 1 exactly while the state is WAIT_MEM.
REQ-007 In WAIT_MEM, reg_op SHALL stay NOP and in_* SHALL be ignored.
REQ-008 In WAIT_MEM with mem_ready=1, the module SHALL:
- output the pending reg_op and wb_addr with wb_data=mem_rdata for one cycle;
- return to IDLE.
REQ-009 in_valid=0 in IDLE, or in_reg_op of 6 or 7, SHALL produce reg_op=NOP on the next edge.
- wb_addr and wb_data hold their previous values.
REQ-010 stall=1 in IDLE SHALL hold reg_op, wb_addr and wb_data unchanged.
- The register file therefore rewrites the same value, which is harmless.
REQ-011 flush=1 SHALL force reg_op=NOP on the next edge.
- flush has priority over stall and in_valid.
- flush in WAIT_MEM SHALL discard the pending load and return to IDLE.
REQ-012 reg_op and wb_addr SHALL change only on posedge, so they are stable at the register file's negedge write.
REQ-013 wb_addr SHALL be passed through unchanged for T, SP, IH and RA ops; the register file ignores it for those ops.

Reset
REQ-014 rst=0 SHALL asynchronously set:
- state=IDLE, busy=0, reg_op=0 (NOP), wb_addr=0, wb_data=16'h0000;
- pending register cleared;
- fwd_A_hit=0, fwd_B_hit=0.
REQ-015 Reset asserted in WAIT_MEM SHALL abandon the load; the first cycle after deassertion behaves as IDLE.

Configuration
REQ-016 Macro WB_FWD_EN SHALL compile the forwarding logic in or out.
- When defined: ports A_addr, B_addr, fwd_A_hit, fwd_B_hit and fwd_data exist.
- fwd_A_hit SHALL be combinationally 1 when reg_op=REG and wb_addr=A_addr; fwd_B_hit likewise for B_addr.
- fwd_data SHALL equal wb_data.
- When undefined: these ports and their logic are absent, and nothing else changes.

Verification
REQ-017 Release rst, apply in_valid=1, in_reg_op=1, in_wb_addr=3, in_alu_data=16'h1234, no load -> next cycle reg_op=1, wb_addr=3, wb_data=16'h1234.
REQ-018 Apply a load to reg 5 with mem_ready=0 for 2 cycles, then mem_rdata=16'hBEEF with mem_ready=1 -> busy=1 for 2 cycles with reg_op=0, then reg_op=1, wb_addr=5, wb_data=16'hBEEF, busy=0.
REQ-019 Apply an SP op with in_alu_data=16'h00FF, and stall=1 and flush=1 together -> reg_op=0 (NOP).
REQ-020 During WAIT_MEM, pulse rst=0 mid-cycle -> outputs go to reset values immediately; a later mem_ready causes no write.
REQ-021 With WB_FWD_EN defined: write reg 2, A_addr=2, B_addr=4 -> fwd_A_hit=1, fwd_B_hit=0, fwd_data=wb_data; a T op to wb_addr 2 -> both hits 0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with a stall-on-load-miss FSM.
// A load whose read data is not ready yet parks its destination in a pending
// register and raises busy until memory answers (WAIT_MEM state).
// Optional feature macro: WB_FWD_EN adds the decode-stage bypass compare
// ports A_addr, B_addr, fwd_A_hit, fwd_B_hit and fwd_data.
module mem_wb_stage (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [2:0]  in_reg_op,
    input  logic [2:0]  in_wb_addr,
    input  logic [15:0] in_alu_data,
    input  logic        in_is_load,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [2:0]  reg_op,
    output logic [2:0]  wb_addr,
    output logic [15:0] wb_data,
    output logic        busy
`ifdef WB_FWD_EN
    ,
    input  logic [2:0]  A_addr,
    input  logic [2:0]  B_addr,
    output logic        fwd_A_hit,
    output logic        fwd_B_hit,
    output logic [15:0] fwd_data
`endif
);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_REG = 3'd1,
        OP_T   = 3'd2,
        OP_SP  = 3'd3,
        OP_IH  = 3'd4,
        OP_RA  = 3'd5
    } reg_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    state_e      state;
    state_e      next_state;

    logic [2:0]  pend_op;
    logic [2:0]  pend_addr;

    logic [2:0]  nxt_reg_op;
    logic [2:0]  nxt_wb_addr;
    logic [15:0] nxt_wb_data;
    logic [2:0]  nxt_pend_op;
    logic [2:0]  nxt_pend_addr;

    // Encodings 6 and 7 are reserved and behave like an empty slot.
    logic        op_ok;
    assign op_ok = (in_reg_op <= OP_RA);

    // Slot that actually enters the stage this cycle (not stalled, real op).
    logic        take;
    assign take = !stall && in_valid && op_ok;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: flush always returns to IDLE, a load miss parks in WAIT_MEM.
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     if (take && in_is_load && !mem_ready) next_state = WAIT_MEM;
                WAIT_MEM: if (mem_ready) next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    // Output logic: next contents of the WB register and the pending load slot.
    always_comb begin
        nxt_reg_op    = reg_op;
        nxt_wb_addr   = wb_addr;
        nxt_wb_data   = wb_data;
        nxt_pend_op   = pend_op;
        nxt_pend_addr = pend_addr;

        if (flush) begin
            // Bubble; a parked load is discarded together with its destination.
            nxt_reg_op    = OP_NOP;
            nxt_pend_op   = OP_NOP;
            nxt_pend_addr = '0;
        end else if (state == WAIT_MEM) begin
            // Upstream is held by busy, so in_* carries nothing meaningful here.
            if (mem_ready) begin
                nxt_reg_op  = pend_op;
                nxt_wb_addr = pend_addr;
                nxt_wb_data = mem_rdata;
            end else begin
                nxt_reg_op  = OP_NOP;
            end
        end else if (stall) begin
            // Hold everything: rewriting the same register value is harmless.
        end else if (!in_valid || !op_ok) begin
            // Empty slot: address and data keep their old values.
            nxt_reg_op = OP_NOP;
        end else if (!in_is_load) begin
            nxt_reg_op  = in_reg_op;
            nxt_wb_addr = in_wb_addr;
            nxt_wb_data = in_alu_data;
        end else if (mem_ready) begin
            nxt_reg_op  = in_reg_op;
            nxt_wb_addr = in_wb_addr;
            nxt_wb_data = mem_rdata;
        end else begin
            nxt_reg_op    = OP_NOP;
            nxt_pend_op   = in_reg_op;
            nxt_pend_addr = in_wb_addr;
        end
    end

    // WB and pending registers; changing only on posedge keeps reg_op/wb_addr
    // stable for the register file's negedge write.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            reg_op    <= OP_NOP;
            wb_addr   <= '0;
            wb_data   <= '0;
            pend_op   <= OP_NOP;
            pend_addr <= '0;
        end else begin
            reg_op    <= nxt_reg_op;
            wb_addr   <= nxt_wb_addr;
            wb_data   <= nxt_wb_data;
            pend_op   <= nxt_pend_op;
            pend_addr <= nxt_pend_addr;
        end
    end

    assign busy = (state == WAIT_MEM);

`ifdef WB_FWD_EN
    // Only general-register writes can bypass into decode-stage operands.
    assign fwd_A_hit = (reg_op == OP_REG) && (wb_addr == A_addr);
    assign fwd_B_hit = (reg_op == OP_REG) && (wb_addr == B_addr);
    assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for mem_wb_stage. Each driven cycle pushes
// the expected WB contents from a small behavioural model; the entry is
// popped and compared one step after the following posedge.
// Define WB_FWD_EN for both files to exercise the bypass ports.
module tb_mem_wb_stage;

    logic        clk_50MHz;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_reg_op;
    logic [2:0]  in_wb_addr;
    logic [15:0] in_alu_data;
    logic        in_is_load;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [2:0]  reg_op;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        busy;
`ifdef WB_FWD_EN
    logic [2:0]  A_addr;
    logic [2:0]  B_addr;
    logic        fwd_A_hit;
    logic        fwd_B_hit;
    logic [15:0] fwd_data;
`endif

    mem_wb_stage dut (
        .clk_50MHz   (clk_50MHz),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_reg_op   (in_reg_op),
        .in_wb_addr  (in_wb_addr),
        .in_alu_data (in_alu_data),
        .in_is_load  (in_is_load),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .reg_op      (reg_op),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy        (busy)
`ifdef WB_FWD_EN
        ,
        .A_addr      (A_addr),
        .B_addr      (B_addr),
        .fwd_A_hit   (fwd_A_hit),
        .fwd_B_hit   (fwd_B_hit),
        .fwd_data    (fwd_data)
`endif
    );

    initial begin
        clk_50MHz = 1'b0;
        forever #10 clk_50MHz = ~clk_50MHz;
    end

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state.
    logic        m_wait;
    logic [2:0]  m_pend_op;
    logic [2:0]  m_pend_addr;
    logic [2:0]  m_op;
    logic [2:0]  m_addr;
    logic [15:0] m_data;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_pend_op = '0; m_pend_addr = '0;
        m_op = '0; m_addr = '0; m_data = '0;
    endtask

    // Drive one cycle, predict the result, then compare after the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [2:0] addr,
                        input logic [15:0] data, input logic ld, input logic [15:0] rd,
                        input logic rdy, input logic st, input logic fl, input string tag);
        exp_t e;
        in_valid = v; in_reg_op = op; in_wb_addr = addr; in_alu_data = data;
        in_is_load = ld; mem_rdata = rd; mem_ready = rdy; stall = st; flush = fl;

        if (fl) begin
            m_op = 3'd0;
            m_wait = 1'b0;
        end else if (m_wait) begin
            if (rdy) begin
                m_op = m_pend_op; m_addr = m_pend_addr; m_data = rd; m_wait = 1'b0;
            end else begin
                m_op = 3'd0;
            end
        end else if (st) begin
            // unchanged
        end else if (!v || op > 3'd5) begin
            m_op = 3'd0;
        end else if (!ld) begin
            m_op = op; m_addr = addr; m_data = data;
        end else if (rdy) begin
            m_op = op; m_addr = addr; m_data = rd;
        end else begin
            m_pend_op = op; m_pend_addr = addr; m_op = 3'd0; m_wait = 1'b1;
        end
        e.op = m_op; e.addr = m_addr; e.data = m_data; e.busy = m_wait;
        q.push_back(e);

        @(posedge clk_50MHz);
        #1;
        if (q.size() == 0) begin
            check({tag, ".queue"}, 16'd0, 16'd1);
        end else begin
            e = q.pop_front();
            check({tag, ".reg_op"},  {13'd0, reg_op},  {13'd0, e.op});
            check({tag, ".wb_addr"}, {13'd0, wb_addr}, {13'd0, e.addr});
            check({tag, ".wb_data"}, wb_data,          e.data);
            check({tag, ".busy"},    {15'd0, busy},    {15'd0, e.busy});
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b0;
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_reg_op = '0; in_wb_addr = '0;
        in_alu_data = '0; in_is_load = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
`ifdef WB_FWD_EN
        A_addr = '0; B_addr = '0;
`endif
        model_reset();
        repeat (2) @(posedge clk_50MHz);
        #1;
        check("reset.reg_op",  {13'd0, reg_op},  16'd0);
        check("reset.wb_addr", {13'd0, wb_addr}, 16'd0);
        check("reset.wb_data", wb_data,          16'h0000);
        check("reset.busy",    {15'd0, busy},    16'd0);
        rst = 1'b1;

        // Plain ALU write to r3.
        step(1'b1, 3'd1, 3'd3, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "alu");
        check("alu.const", wb_data, 16'h1234);

        // Load miss to r5: two busy cycles, then the data arrives.
        step(1'b1, 3'd1, 3'd5, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, "ldmiss0");
        step(1'b1, 3'd2, 3'd7, 16'hAAAA, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "ldmiss1");
        step(1'b1, 3'd2, 3'd7, 16'hAAAA, 1'b0, 16'hBEEF, 1'b1, 1'b0, 1'b0, "ldmiss2");
        check("ldmiss.const", wb_data, 16'hBEEF);

        // Load hit writes memory data in the same edge.
        step(1'b1, 3'd1, 3'd6, 16'h1111, 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, "ldhit");
        // Reserved op codes and empty slots give a NOP and hold addr/data.
        step(1'b1, 3'd6, 3'd1, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "op6");
        step(1'b1, 3'd7, 3'd2, 16'h3333, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "op7");
        idle("invalid");

        // Stall holds; SP op with stall and flush together still gives a NOP.
        step(1'b1, 3'd4, 3'd4, 16'h4444, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "ih");
        step(1'b1, 3'd5, 3'd1, 16'h5555, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, "stall");
        step(1'b1, 3'd3, 3'd0, 16'h00FF, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, "stallflush");
        check("stallflush.const", {13'd0, reg_op}, 16'd0);

        // Flush during WAIT_MEM abandons the load.
        step(1'b1, 3'd1, 3'd2, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, "fl_ld");
        step(1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, "fl_wait");
        idle("fl_after");

        // Async reset in WAIT_MEM: outputs clear immediately, later ready is ignored.
        step(1'b1, 3'd1, 3'd6, 16'h0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0, "rst_ld");
        in_valid = 1'b0;
        #4 rst = 1'b0;
        #1;
        check("arst.reg_op",  {13'd0, reg_op},  16'd0);
        check("arst.wb_addr", {13'd0, wb_addr}, 16'd0);
        check("arst.wb_data", wb_data,          16'h0000);
        check("arst.busy",    {15'd0, busy},    16'd0);
        model_reset();
        #3 rst = 1'b1;
        step(1'b0, 3'd0, 3'd0, 16'h0, 1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, "arst_ready");

`ifdef WB_FWD_EN
        // Bypass compare: REG write to r2 hits A only; a T op never hits.
        A_addr = 3'd2; B_addr = 3'd4;
        step(1'b1, 3'd1, 3'd2, 16'h7777, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "fwd_reg");
        check("fwd.A_hit", {15'd0, fwd_A_hit}, 16'd1);
        check("fwd.B_hit", {15'd0, fwd_B_hit}, 16'd0);
        check("fwd.data",  fwd_data, 16'h7777);
        step(1'b1, 3'd2, 3'd2, 16'h8888, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, "fwd_t");
        check("fwd_t.A_hit", {15'd0, fwd_A_hit}, 16'd0);
        check("fwd_t.B_hit", {15'd0, fwd_B_hit}, 16'd0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom),
                 16'($urandom), 1'($urandom_range(0, 2) == 0), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 11) == 0), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
